// File: rtl/wisc_pkg.sv
// Shared types for the WISC pipeline hazard logic: FSM encodings and the
// scoreboard entry layout used by every pipeline stage tracker.
package wisc_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FROZEN = 2'b01,
    ST_HALTED = 2'b10
  } hz_state_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] wreg;
    logic             load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side request and pipeline-control bundle between the pipeline
// (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
) ();
  import wisc_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [REG_W-1:0] id_write_sel;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_halt;
  logic             branch_taken;
  logic             mem_busy;

  logic             stall_decode;
  logic             hold_pc;
  logic             hold_if_id;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             freeze;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_write_sel,
           id_reg_write, id_mem_read, id_halt, branch_taken, mem_busy,
    input  stall_decode, hold_pc, hold_if_id, flush_if_id, flush_id_ex,
           freeze, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_write_sel,
           id_reg_write, id_mem_read, id_halt, branch_taken, mem_busy,
    output stall_decode, hold_pc, hold_if_id, flush_if_id, flush_id_ex,
           freeze, halted, stall_cnt
  );

endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard stage: holds an in-flight writer plus its halt bit and
// reports whether the decode instruction reads the register it will write.
module hazard_sb_entry
  import wisc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  sb_entry_t        d,
  input  logic             halt_d,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             rs_used,
  input  logic             rt_used,
  output sb_entry_t        q,
  output logic             halt_q,
  output logic             match
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q      <= '0;
      halt_q <= 1'b0;
    end else if (en) begin
      q      <= d;
      halt_q <= halt_d;
    end
  end

  assign match = q.v & ((rs_used & (rs == q.wreg)) | (rt_used & (rt == q.wreg)));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage WISC pipeline: tracks EX/MEM/WB
// writers, raises decode stalls, branch flushes, memory freezes and HALT.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_RUN    | pipeline advancing normally
//   ST_FROZEN | data memory busy, every pipeline register holds
//   ST_HALTED | HALT reached WB, pipe frozen until reset
module hazard_ctrl
  import wisc_pkg::*;
#(
  parameter int FORWARD   = 1,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  hz_state_t        state, state_nxt;
  sb_entry_t        sb_d [3];
  sb_entry_t        sb_q [3];
  logic             halt_d [3];
  logic             halt_q [3];
  logic [2:0]       match;
  logic             raw, freeze_i, advance, flush_i, stall_i;
  logic [CNT_W-1:0] cnt;

  // Stage 0 is EX, 1 is MEM, 2 is WB; all shift together on non-frozen edges.
  always_comb begin
    sb_d[0]   = '{v:    bus.id_valid & bus.id_reg_write & ~stall_i & ~flush_i,
                  wreg: bus.id_write_sel,
                  load: bus.id_mem_read};
    sb_d[1]   = sb_q[0];
    sb_d[2]   = sb_q[1];
    halt_d[0] = bus.id_valid & bus.id_halt & ~stall_i & ~flush_i;
    halt_d[1] = halt_q[0];
    halt_d[2] = halt_q[1];
  end

  for (genvar g = 0; g < 3; g++) begin : g_sb
    hazard_sb_entry u_sb (
      .clk     (clk),
      .rst     (rst),
      .en      (advance),
      .d       (sb_d[g]),
      .halt_d  (halt_d[g]),
      .rs      (bus.id_rs),
      .rt      (bus.id_rt),
      .rs_used (bus.id_rs_used),
      .rt_used (bus.id_rt_used),
      .q       (sb_q[g]),
      .halt_q  (halt_q[g]),
      .match   (match[g])
    );
  end

  // With forwarding only a load in EX cannot be bypassed in time.
  always_comb begin
    if (FORWARD != 0) raw = match[0] & sb_q[0].load;
    else              raw = match[0] | match[1] | ((WB_BYPASS == 0) & match[2]);
    raw = raw & bus.id_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // halt_q[1] is the halt bit about to land in WB; it only moves when not frozen.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (bus.mem_busy) state_nxt = ST_FROZEN;
                 else if (halt_q[1]) state_nxt = ST_HALTED;
      ST_FROZEN: if (!bus.mem_busy) state_nxt = halt_q[1] ? ST_HALTED : ST_RUN;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    freeze_i         = bus.mem_busy | (state == ST_HALTED);
    advance          = ~freeze_i;
    flush_i          = advance & bus.branch_taken;
    stall_i          = advance & ~bus.branch_taken & raw;
    bus.freeze       = rst & freeze_i;
    bus.halted       = rst & (state == ST_HALTED);
    bus.flush_if_id  = rst & flush_i;
    bus.flush_id_ex  = rst & flush_i;
    bus.stall_decode = rst & stall_i;
    bus.hold_pc      = rst & stall_i;
    bus.hold_if_id   = rst & stall_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (advance && stall_i && (cnt != '1)) cnt <= cnt + CNT_W'(1);
  end

  assign bus.stall_cnt = cnt;

endmodule
